// File: rtl/pl_rr_arbiter_pkg.sv
// Shared types for the pipeline-stage handshake family.
// Stage states are common to the arbiter and downstream pipeline stages.
package pl_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    PL_IDLE_ST  = 2'b00,
    PL_EMPTY_ST = 2'b01,
    PL_FULL_ST  = 2'b10
  } pl_state_typ;

endpackage

// File: rtl/pl_rr_arbiter_if.sv
// avail/get handshake bundle between N_REQ producers, the arbiter and one consumer.
// The slave modport is the arbiter's view; master is the environment's view.
interface pl_rr_arbiter_if #(
  parameter int unsigned FXD_N = 32,
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_avail;
  logic [N_REQ-1:0]       req_get;
  logic [N_REQ*FXD_N-1:0] req_data;
  logic                   post_avail;
  logic                   post_get;
  logic [FXD_N-1:0]       post_data;
  logic [ID_W-1:0]        post_id;

  modport slave (
    input  req_avail, req_data, post_get,
    output req_get, post_avail, post_data, post_id
  );

  modport master (
    output req_avail, req_data, post_get,
    input  req_get, post_avail, post_data, post_id
  );
endinterface

// File: rtl/pl_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping modulo N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  int unsigned w_k;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_k     = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      w_k = (int'(i_ptr) + off) % N_REQ;
      if (!o_any && i_req[w_k]) begin
        o_any        = 1'b1;
        o_grant[w_k] = 1'b1;
        o_idx        = ID_W'(w_k);
      end
    end
  end

endmodule

// File: rtl/pl_rr_arbiter.sv
// Round-robin arbiter sharing one registered pipeline stage among N_REQ producers.
// Holds the stage FSM, the rotating priority pointer and the output word/index.
module pl_rr_arbiter
  import pl_rr_arbiter_pkg::*;
#(
  parameter int unsigned FXD_N = 32,
  parameter int unsigned N_REQ = 4
) (
  input  logic          clk,
  input  logic          rst,
  pl_rr_arbiter_if.slave bus
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  pl_state_typ      r_state, w_state_next;
  logic [ID_W-1:0]  r_ptr, w_ptr_next;
  logic [FXD_N-1:0] r_data;
  logic [ID_W-1:0]  r_id;

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic             w_acc;
  logic             w_xfer;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req   (bus.req_avail),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // A full stage can take a new word only in the cycle its current word leaves.
  assign w_acc  = (r_state == PL_EMPTY_ST) || ((r_state == PL_FULL_ST) && bus.post_get);
  assign w_xfer = w_acc && w_any;
  assign w_ptr_next = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + ID_W'(1);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      PL_IDLE_ST:  w_state_next = PL_EMPTY_ST;
      PL_EMPTY_ST: if (w_any) w_state_next = PL_FULL_ST;
      PL_FULL_ST:  if (bus.post_get && !w_any) w_state_next = PL_EMPTY_ST;
      default:     w_state_next = PL_IDLE_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PL_IDLE_ST;
      r_ptr   <= '0;
      r_data  <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_xfer) begin
        r_data <= bus.req_data[w_idx*FXD_N +: FXD_N];
        r_id   <= w_idx;
        r_ptr  <= w_ptr_next;
      end
    end
  end

  assign bus.req_get    = w_acc ? w_grant : '0;
  assign bus.post_avail = (r_state == PL_FULL_ST);
  assign bus.post_data  = r_data;
  assign bus.post_id    = r_id;

endmodule

// File: tb/tb_pl_rr_arbiter.sv
// Directed self-checking bench for pl_rr_arbiter (FXD_N=32, N_REQ=4).
module tb_pl_rr_arbiter;

  localparam int unsigned FXD_N = 32;
  localparam int unsigned N_REQ = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pl_rr_arbiter_if #(.FXD_N(FXD_N), .N_REQ(N_REQ)) bus ();

  pl_rr_arbiter #(
    .FXD_N (FXD_N),
    .N_REQ (N_REQ)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_post(input string tag, input logic av, input logic [1:0] id,
                            input logic [31:0] data);
    check_val({tag, "_avail"}, 64'(bus.post_avail), 64'(av));
    check_val({tag, "_id"}, 64'(bus.post_id), 64'(id));
    check_val({tag, "_data"}, 64'(bus.post_data), 64'(data));
  endtask

  initial begin
    logic [1:0] rr_ids [6];
    rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.req_avail = 4'b1111;
    bus.req_data  = '0;
    bus.post_get  = 1'b0;

    // 1: reset with all requesters active
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_req_get", 64'(bus.req_get), 64'h0);
      check_val("rst_post_avail", 64'(bus.post_avail), 64'h0);
    end
    check_post("rst_regs", 1'b0, 2'd0, 32'h0);
    rst = 1'b0;
    settle();
    check_val("idle_req_get", 64'(bus.req_get), 64'h0);
    check_val("idle_post_avail", 64'(bus.post_avail), 64'h0);
    bus.req_avail = 4'b0000;
    tick();

    // 2: single source on index 2
    bus.req_avail = 4'b0100;
    bus.req_data  = {32'hDEAD_0003, 32'h0000_1234, 32'hDEAD_0001, 32'hDEAD_0000};
    bus.post_get  = 1'b1;
    settle();
    check_val("single_get0", 64'(bus.req_get), 64'b0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_post("single_post", 1'b1, 2'd2, 32'h0000_1234);
      check_val("single_get", 64'(bus.req_get), 64'b0100);
    end
    bus.req_avail = 4'b0000;
    tick();
    check_val("drain_post_avail", 64'(bus.post_avail), 64'h0);

    // 3: round robin over all four, starting from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.req_data  = {32'd3, 32'd2, 32'd1, 32'd0};
    bus.req_avail = 4'b1111;
    bus.post_get  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      check_val("rr_get", 64'(bus.req_get), 64'(4'b0001 << rr_ids[i]));
      tick();
      check_post("rr_post", 1'b1, rr_ids[i], 32'(rr_ids[i]));
    end

    // 4: backpressure while holding id 1
    bus.post_get = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_val("bp_get", 64'(bus.req_get), 64'h0);
      tick();
      check_post("bp_post", 1'b1, 2'd1, 32'd1);
    end
    bus.post_get = 1'b1;
    settle();
    check_val("bp_release_get", 64'(bus.req_get), 64'b0100);
    tick();
    check_post("bp_release_post", 1'b1, 2'd2, 32'd2);

    // 5: sparse requests with pointer at 3 wrap to 0
    bus.req_avail = 4'b0011;
    settle();
    check_val("wrap_get0", 64'(bus.req_get), 64'b0001);
    tick();
    check_post("wrap_post0", 1'b1, 2'd0, 32'd0);
    check_val("wrap_get1", 64'(bus.req_get), 64'b0010);
    tick();
    check_post("wrap_post1", 1'b1, 2'd1, 32'd1);
    check_val("wrap_get2", 64'(bus.req_get), 64'b0001);
    tick();
    check_post("wrap_post2", 1'b1, 2'd0, 32'd0);

    // 6: reset while full and stalled; pointer would otherwise favour index 2
    bus.post_get  = 1'b0;
    bus.req_avail = 4'b1101;
    settle();
    check_val("mid_stall_get", 64'(bus.req_get), 64'h0);
    rst = 1'b1;
    tick();
    check_post("mid_rst", 1'b0, 2'd0, 32'h0);
    check_val("mid_rst_get", 64'(bus.req_get), 64'h0);
    rst = 1'b0;
    bus.post_get = 1'b1;
    settle();
    check_val("mid_idle_get", 64'(bus.req_get), 64'h0);
    tick();
    check_val("mid_first_get", 64'(bus.req_get), 64'b0001);
    tick();
    check_post("mid_first_post", 1'b1, 2'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
